// File: rtl/counter_proc_pkg.sv
// Shared types for the counter processor core: controller states and run modes.
package counter_proc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TEST   = 3'd1,
    EMIT   = 3'd2,
    UPDATE = 3'd3,
    FIN    = 3'd4
  } state_e;

  typedef enum logic {
    MODE_COUNT = 1'b0,
    MODE_ACCUM = 1'b1
  } mode_e;

endpackage

// File: rtl/counter_proc_ctrl.sv
// Loop controller for the counter processor: sequences TEST/EMIT/UPDATE/FIN and
// issues load strobes to the datapath held in counter_proc_core.
module counter_proc_ctrl
  import counter_proc_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   start_i,
  input  logic   abort_i,
  input  logic   a_lt_limit_i,
  input  logic   carry_i,
  input  logic   out_ready_i,
  output logic   load_init_o,
  output logic   a_load_o,
  output logic   s_load_o,
  output logic   out_valid_o,
  output logic   done_o,
  output state_e state_o
);

  state_e state_q;
  logic   out_valid_q;
  logic   done_q;

  // Strobes act on the same edge as the transition, so they decode the current state.
  assign load_init_o = (state_q == IDLE) && start_i && !abort_i;
  assign a_load_o    = (state_q == UPDATE) && !abort_i;
  assign s_load_o    = (state_q == UPDATE) && !abort_i;
  assign out_valid_o = out_valid_q;
  assign done_o      = done_q;
  assign state_o     = state_q;

  // out_valid/done are registered: each is set on the edge that enters EMIT/FIN.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i && !abort_i) state_q <= TEST;
        end
        TEST: begin
          if (abort_i) begin
            state_q <= IDLE;
          end else if (a_lt_limit_i) begin
            state_q     <= EMIT;
            out_valid_q <= 1'b1;
          end else begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end
        end
        EMIT: begin
          if (abort_i) begin
            state_q <= IDLE;
          end else if (out_ready_i) begin
            state_q <= UPDATE;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        UPDATE: begin
          if (abort_i) begin
            state_q <= IDLE;
          end else if (carry_i) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end else begin
            state_q <= TEST;
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/counter_proc_core.sv
// Counter processor: runs "A=0; while (A < limit) { emit; A += STEP }", emitting A or the
// running sum S. oOut transfers when oOutValid && iOutReady; it is held stable while stalled.
module counter_proc_core
  import counter_proc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic             iAbort,
  input  logic             iMode,
  input  logic [WIDTH-1:0] iLimit,
  output logic             oOutValid,
  input  logic             iOutReady,
  output logic [WIDTH-1:0] oOut,
  output logic             oBusy,
  output logic             oDone,
  output logic             oOverflow
);

  localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  mode_e            mode_q, mode_d;
  logic             ovf_q, ovf_d;

  logic             load_init, a_load, s_load, out_valid, done;
  logic             a_lt_limit, carry;
  logic [WIDTH:0]   a_sum, s_sum;
  state_e           ctrl_state;

  // Only the carry bit of each adder matters; a carry ends the run so the wrapped value is never emitted.
  assign a_sum      = {1'b0, a_q} + STEP_W;
  assign s_sum      = {1'b0, s_q} + {1'b0, a_sum[WIDTH-1:0]};
  assign carry      = a_sum[WIDTH] | ((mode_q == MODE_ACCUM) & s_sum[WIDTH]);
  assign a_lt_limit = (a_q < limit_q);

  counter_proc_ctrl u_ctrl (
    .clk_i        (iClk),
    .rst_i        (iRst),
    .start_i      (iStart),
    .abort_i      (iAbort),
    .a_lt_limit_i (a_lt_limit),
    .carry_i      (carry),
    .out_ready_i  (iOutReady),
    .load_init_o  (load_init),
    .a_load_o     (a_load),
    .s_load_o     (s_load),
    .out_valid_o  (out_valid),
    .done_o       (done),
    .state_o      (ctrl_state)
  );

  always_comb begin
    a_d     = a_q;
    s_d     = s_q;
    limit_d = limit_q;
    mode_d  = mode_q;
    ovf_d   = ovf_q;
    if (load_init) begin
      a_d     = '0;
      s_d     = '0;
      limit_d = iLimit;
      mode_d  = mode_e'(iMode);
      ovf_d   = 1'b0;
    end else if (a_load) begin
      a_d = a_sum[WIDTH-1:0];
      if (s_load && (mode_q == MODE_ACCUM)) s_d = s_sum[WIDTH-1:0];
      if (carry) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      a_q     <= '0;
      s_q     <= '0;
      limit_q <= '0;
      mode_q  <= MODE_COUNT;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      s_q     <= s_d;
      limit_q <= limit_d;
      mode_q  <= mode_d;
      ovf_q   <= ovf_d;
    end
  end

  assign oOutValid = out_valid;
  assign oOut      = out_valid ? ((mode_q == MODE_ACCUM) ? s_q : a_q) : '0;
  assign oBusy     = (ctrl_state != IDLE);
  assign oDone     = done;
  assign oOverflow = ovf_q;

endmodule
